// File: rtl/core_seq_pkg.sv
// ============================================================================
//  Module   : core_seq_pkg
//  Purpose  : Shared types and constants for the systolic-core sequencer.
//             Holds the FSM state enum, the address-generator phase select,
//             the 52-bit instruction bit map and the idle instruction word.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_seq_pkg;

  // Sequencer phases, one per step of a kij pass
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_W_L0   = 4'd2,
    S_W_LOAD = 4'd3,
    S_GAP    = 4'd4,
    S_X_L0   = 4'd5,
    S_EXEC   = 4'd6,
    S_DRAIN  = 4'd7,
    S_O_RD   = 4'd8,
    S_NEXT   = 4'd9
  } state_e;

  // Which memory the shared address generator is serving
  typedef enum logic [1:0] {
    ASEL_W = 2'd0,
    ASEL_X = 2'd1,
    ASEL_O = 2'd2
  } addr_sel_e;

  localparam int INST_BITS = 52;
  localparam int INST_A_W  = 11;   // width of each SRAM address field

  // Instruction bit positions (address fields give their LSB)
  localparam int INST_CEN_OMEM     = 50;
  localparam int INST_WEN_OMEM     = 49;
  localparam int INST_A_OMEM       = 38;
  localparam int INST_ALL_ROW_MODE = 37;
  localparam int INST_L0_RD_MODE   = 36;
  localparam int INST_MODE         = 35;
  localparam int INST_DATA_MODE    = 34;
  localparam int INST_ACC          = 33;
  localparam int INST_CEN_PMEM     = 32;
  localparam int INST_WEN_PMEM     = 31;
  localparam int INST_A_PMEM       = 20;
  localparam int INST_CEN_XMEM     = 19;
  localparam int INST_WEN_XMEM     = 18;
  localparam int INST_A_XMEM       = 7;
  localparam int INST_OFIFO_RD     = 6;
  localparam int INST_IFIFO_WR     = 5;
  localparam int INST_IFIFO_RD     = 4;
  localparam int INST_L0_RD        = 3;
  localparam int INST_L0_WR        = 2;
  localparam int INST_EXECUTE      = 1;
  localparam int INST_LOAD         = 0;

  // All SRAM chip-enables and write-enables deasserted (bits 50,49,32,31,19,18)
  localparam logic [INST_BITS-1:0] INST_IDLE = 52'h6_0001_800C_0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_ctrl_addr_gen.sv
// ============================================================================
//  Module   : core_seq_addr_gen
//  Purpose  : Combinational SRAM address generator shared by all phases.
//             addr = base + kij*stride + offset (mod 2^AW), where
//               ASEL_W : w_base, stride COL,     offset cnt
//               ASEL_X : x_base, stride 0,       offset cnt
//               ASEL_O : o_base, stride LEN_NIJ, offset cnt-1 (lead cycle)
//  Ports    : sel            phase select
//             w/x/o_base     latched base addresses
//             kij            current pass index
//             cnt            per-state cycle counter
//             addr           generated address
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_seq_addr_gen
  import core_seq_pkg::*;
#(
  parameter int AW      = 11,
  parameter int COL     = 8,
  parameter int LEN_NIJ = 36,
  parameter int KW      = 4,
  parameter int CW      = 7
) (
  input  addr_sel_e       sel,
  input  logic [AW-1:0]   w_base,
  input  logic [AW-1:0]   x_base,
  input  logic [AW-1:0]   o_base,
  input  logic [KW-1:0]   kij,
  input  logic [CW-1:0]   cnt,
  output logic [AW-1:0]   addr
);

  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [AW-1:0] offset;

  always_comb begin
    base   = x_base;
    stride = '0;
    offset = AW'(cnt);
    case (sel)
      ASEL_W: begin
        base   = w_base;
        stride = AW'(COL);
      end
      ASEL_O: begin
        base   = o_base;
        stride = AW'(LEN_NIJ);
        // O_RD spends cnt==0 on the FIFO lead read, so writes start at cnt==1
        offset = AW'(cnt) - AW'(1);
      end
      default: ;
    endcase
  end

  // All terms are AW bits wide, so the sum wraps silently modulo 2^AW
  assign addr = base + (AW'(kij) * stride) + offset;

endmodule

`default_nettype wire

// File: rtl/core_seq_ctrl.sv
// ============================================================================
//  Module   : core_seq_ctrl
//  Purpose  : Autonomous instruction sequencer for the systolic-array core.
//             Per kij pass: clear, weight fill, weight load, gap, activation
//             fill, execute, drain wait, OFIFO -> omem write-back.
//  Ports    : clk, reset (async, active-low)
//             start, num_kij, w_base, x_base, o_base   run request (IDLE only)
//             ofifo_valid                               core output ready
//             inst                                      registered inst word
//             core_clr, busy, done, err, kij_idx        status
//             cycle_cnt [31:0]                          only with CORE_SEQ_PERF_EN
//  Config   : `define CORE_SEQ_PERF_EN adds the busy-cycle counter output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int LEN_NIJ   = 36,
  parameter int MAX_KIJ   = 9,
  parameter int AW        = 11,
  parameter int CLR_CYC   = 10,
  parameter int GAP_CYC   = 10,
  parameter int DRAIN_MAX = 64,
  parameter int INST_W    = 52
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_KIJ+1)-1:0]   num_kij,
  input  logic [AW-1:0]                  w_base,
  input  logic [AW-1:0]                  x_base,
  input  logic [AW-1:0]                  o_base,
  input  logic                           ofifo_valid,
  output logic [INST_W-1:0]              inst,
  output logic                           core_clr,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(MAX_KIJ)-1:0]     kij_idx
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]                    cycle_cnt
`endif
);

  localparam int NKW     = $clog2(MAX_KIJ + 1);
  localparam int KW      = $clog2(MAX_KIJ);
  localparam int CNT_MAX = max2(max2(max2(CLR_CYC, GAP_CYC), max2(COL, LEN_NIJ + 1)), DRAIN_MAX);
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Reject parameter sets the instruction map or counters cannot represent
  if (ROW < 1 || COL < 1 || LEN_NIJ < 1 || MAX_KIJ < 2 || AW > INST_A_W ||
      INST_W != INST_BITS) begin : g_cfg_check
    $error("core_seq_ctrl: unsupported parameter set");
  end

  state_e          state;
  state_e          state_nx;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   kij;
  logic [NKW-1:0]  nk;
  logic [AW-1:0]   wb;
  logic [AW-1:0]   xb;
  logic [AW-1:0]   ob;

  logic            accept;
  logic            timeout;
  logic            kij_step;
  logic            kij_clr;
  logic            more_kij;
  logic [NKW:0]    kij_p1;
  logic [NKW-1:0]  nk_clamp;

  addr_sel_e       addr_sel;
  logic [AW-1:0]   addr;
  logic [INST_BITS-1:0] inst_nx;

  assign nk_clamp = (num_kij > NKW'(MAX_KIJ)) ? NKW'(MAX_KIJ) : num_kij;
  assign kij_p1   = (NKW + 1)'(kij) + (NKW + 1)'(1);
  assign more_kij = kij_p1 < {1'b0, nk};

  // --------------------------------------------------------------------------
  // State register, per-state counter and latched run configuration
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      kij   <= '0;
      nk    <= '0;
      wb    <= '0;
      xb    <= '0;
      ob    <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        nk  <= nk_clamp;
        wb  <= w_base;
        xb  <= x_base;
        ob  <= o_base;
        kij <= '0;
      end else if (kij_step) begin
        kij <= kij + KW'(1);
      end else if (kij_clr) begin
        kij <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    timeout  = 1'b0;
    kij_step = 1'b0;
    kij_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_kij != '0) state_nx = S_CLR;
        end
      end
      S_CLR:    if (cnt == CW'(CLR_CYC - 1)) state_nx = S_W_L0;
      S_W_L0:   if (cnt == CW'(COL - 1))     state_nx = S_W_LOAD;
      S_W_LOAD: if (cnt == CW'(COL - 1))     state_nx = S_GAP;
      S_GAP:    if (cnt == CW'(GAP_CYC - 1)) state_nx = S_X_L0;
      S_X_L0:   if (cnt == CW'(LEN_NIJ - 1)) state_nx = S_EXEC;
      S_EXEC:   if (cnt == CW'(LEN_NIJ - 1)) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (ofifo_valid) begin
          state_nx = S_O_RD;
        end else if (cnt == CW'(DRAIN_MAX - 1)) begin
          state_nx = S_NEXT;
          timeout  = 1'b1;
        end
      end
      // cnt 0 is the lead read; cnt 1..LEN_NIJ are the write-back beats
      S_O_RD:   if (cnt == CW'(LEN_NIJ))     state_nx = S_NEXT;
      S_NEXT: begin
        if (more_kij) begin
          kij_step = 1'b1;
          state_nx = S_CLR;
        end else begin
          kij_clr  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction word for the current state (registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    inst_nx  = INST_IDLE;
    addr_sel = ASEL_X;
    // Fields this sequencer never uses stay low
    inst_nx[INST_ALL_ROW_MODE] = 1'b0;
    inst_nx[INST_ACC]          = 1'b0;
    inst_nx[INST_IFIFO_WR]     = 1'b0;
    inst_nx[INST_IFIFO_RD]     = 1'b0;
    case (state)
      S_W_L0: begin
        addr_sel                           = ASEL_W;
        inst_nx[INST_MODE]                 = 1'b1;
        inst_nx[INST_DATA_MODE]            = 1'b1;
        inst_nx[INST_CEN_PMEM]             = 1'b0;
        inst_nx[INST_WEN_PMEM]             = 1'b1;
        inst_nx[INST_A_PMEM +: INST_A_W]   = INST_A_W'(addr);
        inst_nx[INST_L0_WR]                = 1'b1;
      end
      S_W_LOAD: begin
        inst_nx[INST_L0_RD]      = 1'b1;
        inst_nx[INST_L0_RD_MODE] = 1'b1;
        inst_nx[INST_LOAD]       = 1'b1;
      end
      S_GAP: begin
        inst_nx[INST_MODE] = 1'b1;
      end
      S_X_L0: begin
        addr_sel                           = ASEL_X;
        inst_nx[INST_MODE]                 = 1'b1;
        inst_nx[INST_DATA_MODE]            = 1'b0;
        inst_nx[INST_CEN_XMEM]             = 1'b0;
        inst_nx[INST_WEN_XMEM]             = 1'b1;
        inst_nx[INST_A_XMEM +: INST_A_W]   = INST_A_W'(addr);
        inst_nx[INST_L0_WR]                = 1'b1;
      end
      S_EXEC: begin
        inst_nx[INST_L0_RD]      = 1'b1;
        inst_nx[INST_L0_RD_MODE] = 1'b0;
        inst_nx[INST_LOAD]       = 1'b1;
        inst_nx[INST_EXECUTE]    = 1'b1;
      end
      S_O_RD: begin
        addr_sel               = ASEL_O;
        inst_nx[INST_OFIFO_RD] = 1'b1;
        if (cnt != '0) begin
          inst_nx[INST_CEN_OMEM]           = 1'b0;
          inst_nx[INST_WEN_OMEM]           = 1'b0;
          inst_nx[INST_A_OMEM +: INST_A_W] = INST_A_W'(addr);
        end
      end
      default: ;
    endcase
  end

  core_seq_addr_gen #(
    .AW      (AW),
    .COL     (COL),
    .LEN_NIJ (LEN_NIJ),
    .KW      (KW),
    .CW      (CW)
  ) u_addr_gen (
    .sel     (addr_sel),
    .w_base  (wb),
    .x_base  (xb),
    .o_base  (ob),
    .kij     (kij),
    .cnt     (cnt),
    .addr    (addr)
  );

  // --------------------------------------------------------------------------
  // Output registers: every output reflects the state held in the prior cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst     <= INST_W'(INST_IDLE);
      core_clr <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      kij_idx  <= '0;
    end else begin
      inst     <= INST_W'(inst_nx);
      core_clr <= (state == S_CLR);
      busy     <= (state != S_IDLE);
      done     <= (state == S_NEXT && state_nx == S_IDLE) ||
                  (accept && num_kij == '0);
      kij_idx  <= kij;
      if (accept) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (state != S_IDLE && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Autonomous instruction sequencer for the systolic-array core. It replaces hand-driven instruction stepping with a registered FSM.
- For each kernel offset kij, it runs: core clear, pmem→L0 weight fill, weight load into PEs, intermission, xmem→L0 activation fill, execute, drain, then OFIFO→omem write-back.
- Drives the core's 52-bit inst bus directly and is generalised in array size, nij length, kij count and base addresses.

Parameters:
- ROW, 8, array rows (activation lanes)
- COL, 8, array columns; weight words per kij
- LEN_NIJ, 36, activation words per kij pass
- MAX_KIJ, 9, maximum kernel offsets per run
- AW, 11, SRAM address width
- CLR_CYC, 10, core_clr pulse length
- GAP_CYC, 10, idle cycles after weight load
- DRAIN_MAX, 64, OFIFO-valid wait timeout in cycles
- INST_W, 52, inst bus width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  begin run; sampled only in IDLE
- num_kij  in  $clog2(MAX_KIJ+1)  kij passes this run
- w_base  in  AW  pmem base of weights; kij k occupies w_base+k*COL
- x_base  in  AW  xmem base of activations
- o_base  in  AW  omem base; kij k writes o_base+k*LEN_NIJ
- ofifo_valid  in  1  from core
- inst  out  INST_W  core instruction word (registered)
- core_clr  out  1  active-high core clear
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run end
- err  out  1  sticky drain timeout; cleared by next accepted start
- kij_idx  out  $clog2(MAX_KIJ)  current pass

Behaviour:
- inst field map:
  - bit 51 = 0
  - 50 CEN_omem, 49 WEN_omem, 48:38 A_omem
  - 37 all_row_mode, 36 l0_rd_mode, 35 mode, 34 data_mode, 33 acc
  - 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem
  - 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem
  - 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load
- Idle inst value: all CEN/WEN bits = 1; all other bits 0.
- Reset values: inst = idle value; core_clr = 0, busy = 0, done = 0, err = 0, kij_idx = 0; state = IDLE. Reset asserted mid-run aborts immediately; no partial write continues.
- All outputs are registered. A state's first inst word appears the cycle after entry.
- States (per-state counter cnt restarts at 0 on every entry):
  - IDLE: on start && num_kij != 0, go to CLR. On start && num_kij == 0, pulse done and stay. start while busy is ignored.
  - CLR: core_clr = 1 for CLR_CYC cycles.
  - W_L0: COL cycles. mode = 1, data_mode = 1, CEN_pmem = 0, WEN_pmem = 1, A_pmem = w_base + kij*COL + cnt, l0_wr = 1.
  - W_LOAD: COL cycles. l0_rd = 1, l0_rd_mode = 1, load = 1.
  - GAP: GAP_CYC cycles of the idle value, except mode = 1 held.
  - X_L0: LEN_NIJ cycles. mode = 1, data_mode = 0, CEN_xmem = 0, WEN_xmem = 1, A_xmem = x_base + cnt, l0_wr = 1.
  - EXEC: LEN_NIJ cycles. l0_rd = 1, l0_rd_mode = 0, load = 1, execute = 1.
  - DRAIN: wait for ofifo_valid. If DRAIN_MAX cycles elapse first, set err and go to NEXT, skipping write-back.
  - O_RD: one lead cycle with ofifo_rd = 1 only. Then LEN_NIJ cycles of ofifo_rd = 1, CEN_omem = 0, WEN_omem = 0, A_omem = o_base + kij*LEN_NIJ + cnt.
  - NEXT: kij_idx + 1 < num_kij → kij_idx++, go to CLR. Otherwise go to IDLE with a done pulse and kij_idx = 0.
- Address arithmetic is modulo 2^AW; wrap is silent.
- num_kij > MAX_KIJ is clamped to MAX_KIJ.

Optional Feature:
- Macro CORE_SEQ_PERF_EN.
- Defined: adds output cycle_cnt [31:0]. It clears on accepted start, increments every busy cycle, saturates at all-ones, and holds after done.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package core_seq_pkg holds:
  - state enum
  - inst bit-position constants (INST_CEN_OMEM ... INST_LOAD)
  - INST_IDLE constant
- Sub-module core_seq_addr_gen: per-phase base + offset + counter address generator, instanced once and muxed by state.

Test Plan:
- num_kij = 1, bases 0, ofifo_valid high 5 cycles into DRAIN → 8 pmem reads at A 0..7, then 36 xmem reads at A 0..36-1, then 36 omem writes at A 0..35; done pulses once; busy length matches the per-state cycle sum.
- num_kij = 9, w_base = 100, o_base = 200 → pass 8 reads pmem 164..171 and writes omem 488..523; kij_idx steps 0..8; core_clr high 10 cycles per pass.
- ofifo_valid held low → after 64 DRAIN cycles err = 1, no omem write occurs, and the next pass proceeds; next start clears err.
- Reset driven low mid-EXEC → outputs take reset values asynchronously; a fresh start reruns from kij 0.
- start pulsed during busy → ignored. num_kij = 0 → done the cycle after start, with no CEN asserted.
- With CORE_SEQ_PERF_EN, the single-kij run → cycle_cnt equals the busy cycle count and holds after done.
